// File: rtl/dnn_macbuff_pkg.sv
// dnn_macbuff_pkg: shared FSM state type and width/latency helpers for the MAC buffer
package dnn_macbuff_pkg;
  typedef enum logic [1:0] {FILL, DRAIN, FULL, READ} fsm_state_t;
  function automatic int mac_lat(input int lanes);
    return 3 + $clog2(lanes);
  endfunction
  function automatic int result_w(input int ow, input int lanes);
    return 2 * ow + $clog2(lanes);
  endfunction
endpackage

// File: rtl/dnn_adder_tree.sv
// dnn_adder_tree: pipelined pairwise reduction, one register per level, with valid and sideband.
module dnn_adder_tree #(
  parameter int LANES = 4,
  parameter int IW    = 33,
  parameter int OW    = 34,
  parameter int SB    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [SB-1:0]         sb_i,
  input  logic [LANES*IW-1:0]   in_i,
  output logic                  valid_o,
  output logic [SB-1:0]         sb_o,
  output logic [OW-1:0]         sum_o
);
  localparam int LV = $clog2(LANES);
  for (genvar l = 0; l <= LV; l++) begin : g_lv
    localparam int N = LANES >> l;
    logic [OW-1:0] s [N];
    logic v;
    logic [SB-1:0] sb;
    if (l == 0) begin : g_in
      // Products are sign-extended; unsigned products have a zero top bit so this is exact.
      for (genvar i = 0; i < LANES; i++) begin : g_ext
        assign s[i] = OW'($signed(in_i[i*IW +: IW]));
      end
      assign v = valid_i;
      assign sb = sb_i;
    end else begin : g_add
      always_ff @(posedge clk) begin
        v <= rst ? 1'b0 : g_lv[l-1].v;
        sb <= g_lv[l-1].sb;
        for (int k = 0; k < N; k++) s[k] <= g_lv[l-1].s[2*k] + g_lv[l-1].s[2*k+1];
      end
    end
  end
  assign valid_o = g_lv[LV].v;
  assign sb_o = g_lv[LV].sb;
  assign sum_o = g_lv[LV].s[0];
endmodule

// File: rtl/multiplier_module.sv
// multiplier_module: two-stage W x W multiplier, signed or unsigned per operation.
// The product carries one extra sign bit so both modes share one signed datapath.
module multiplier_module #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           signed_i,
  output logic [2*W:0]   p_o
);
  logic signed [W:0] a_x, b_x;
  logic signed [2*W+1:0] prod;
  logic [2*W:0] p_q;
  assign a_x = {signed_i & a_i[W-1], a_i};
  assign b_x = {signed_i & b_i[W-1], b_i};
  assign prod = a_x * b_x;
  always_ff @(posedge clk) begin
    p_q <= prod[2*W:0];
    p_o <= p_q;
  end
endmodule

// File: rtl/dnn_macbuff_param.sv
// dnn_macbuff_param: LANES-wide dot-product engine that fills a 2-port result memory, then streams it back.
// Optional macro DNN_MACBUFF_RELU_EN adds relu_en, clamping negative signed results to zero.
module dnn_macbuff_param import dnn_macbuff_pkg::*; #(
  parameter int LANES         = 4,
  parameter int OPERAND_WIDTH = 16,
  parameter int ADDR_WIDTH    = 6,
  parameter int RESULT_WIDTH  = result_w(OPERAND_WIDTH, LANES)
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             EN_mac,
  output logic                             RDY_mac,
  input  logic [LANES*OPERAND_WIDTH-1:0]   mac_vectA,
  input  logic [LANES*OPERAND_WIDTH-1:0]   mac_vectB,
  input  logic                             mac_signed,
`ifdef DNN_MACBUFF_RELU_EN
  input  logic                             relu_en,
`endif
  output logic                             EN_writeMem,
  output logic [ADDR_WIDTH-1:0]            writeMem_addr,
  output logic [RESULT_WIDTH-1:0]          writeMem_val,
  input  logic                             EN_blockRead,
  input  logic [ADDR_WIDTH:0]              blockRead_len,
  output logic                             RDY_blockRead,
  output logic                             EN_readMem,
  output logic [ADDR_WIDTH-1:0]            readMem_addr,
  input  logic [RESULT_WIDTH-1:0]          readMem_val,
  output logic                             VALID_memVal,
  output logic [RESULT_WIDTH-1:0]          memVal_data
);
  localparam int OW = OPERAND_WIDTH;
  localparam int PW = 2 * OW + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);
  fsm_state_t state_q, state_d;
  logic [ADDR_WIDTH:0] issue_q, issue_d, write_q, write_d, rd_q, rd_d, ret_q, ret_d, len_q, len_d;
  logic [LANES*OW-1:0] a_q, b_q;
  logic [LANES*PW-1:0] prod;
  logic sgn_q, relu_q, v1_q, pend_q, vld_q, accept, relu_in, tree_v;
  logic [1:0] vm_q, sb2_q, sb3_q, tree_sb;
  logic [RESULT_WIDTH-1:0] data_q, sum;
`ifdef DNN_MACBUFF_RELU_EN
  assign relu_in = relu_en;
`else
  assign relu_in = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    v1_q <= !RESET && accept;
    vm_q <= RESET ? 2'b00 : {vm_q[0], v1_q};
    sb2_q <= {sgn_q, relu_q};
    sb3_q <= sb2_q;
    if (accept) begin
      a_q <= mac_vectA;
      b_q <= mac_vectB;
      sgn_q <= mac_signed;
      relu_q <= relu_in;
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_mul
    multiplier_module #(.W(OW)) u_mul (
      .clk(CLK), .a_i(a_q[i*OW +: OW]), .b_i(b_q[i*OW +: OW]), .signed_i(sgn_q), .p_o(prod[i*PW +: PW])
    );
  end
  dnn_adder_tree #(.LANES(LANES), .IW(PW), .OW(RESULT_WIDTH), .SB(2)) u_tree (
    .clk(CLK), .rst(RESET), .valid_i(vm_q[1]), .sb_i(sb3_q), .in_i(prod),
    .valid_o(tree_v), .sb_o(tree_sb), .sum_o(sum)
  );
  // sideband is {signed, relu}; the value is forced to 0 when idle so the port is quiet
  assign EN_writeMem = tree_v;
  assign writeMem_addr = write_q[ADDR_WIDTH-1:0];
  assign writeMem_val = (tree_v && !(tree_sb[1] && tree_sb[0] && sum[RESULT_WIDTH-1])) ? sum : '0;
  assign readMem_addr = rd_q[ADDR_WIDTH-1:0];
  assign VALID_memVal = vld_q;
  assign memVal_data = data_q;
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    write_d = write_q + {{ADDR_WIDTH{1'b0}}, tree_v};
    rd_d = rd_q;
    ret_d = ret_q;
    len_d = len_q;
    RDY_mac = state_q == FILL && issue_q < DEPTH_C;
    RDY_blockRead = state_q == FULL;
    EN_readMem = state_q == READ && rd_q < len_q;
    accept = EN_mac && RDY_mac;
    if (accept) issue_d = issue_q + 1'b1;
    if (EN_readMem) rd_d = rd_q + 1'b1;
    if (vld_q) ret_d = ret_q + 1'b1;
    if (accept && issue_q == DEPTH_C - 1'b1) state_d = DRAIN;
    if (state_q == DRAIN && write_q == DEPTH_C) state_d = FULL;
    if (state_q == FULL && EN_blockRead) begin
      state_d = READ;
      len_d = (blockRead_len == '0 || blockRead_len > DEPTH_C) ? DEPTH_C : blockRead_len;
    end
    if (state_q == READ && vld_q && ret_q == len_q - 1'b1) begin
      state_d = FILL;
      issue_d = '0;
      write_d = '0;
      rd_d = '0;
      ret_d = '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= FILL;
      issue_q <= '0;
      write_q <= '0;
      rd_q <= '0;
      ret_q <= '0;
      len_q <= '0;
      pend_q <= 1'b0;
      vld_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      write_q <= write_d;
      rd_q <= rd_d;
      ret_q <= ret_d;
      len_q <= len_d;
      pend_q <= EN_readMem;
      vld_q <= pend_q;
      if (pend_q) data_q <= readMem_val;
    end
  end
endmodule

// File: tb/tb_dnn_macbuff_param.sv
// tb_dnn_macbuff_param: scoreboard bench for the MAC buffer, default build plus an 8-lane instance.
module tb_dnn_macbuff_param;
  import dnn_macbuff_pkg::*;
  logic CLK = 1'b0, RESET = 1'b1, EN_mac = 1'b0, mac_signed = 1'b0, EN_blockRead = 1'b0;
  logic [63:0] mac_vectA = '0, mac_vectB = '0;
  logic [6:0] blockRead_len = '0;
  logic [33:0] readMem_val = '0;
  logic RDY_mac, EN_writeMem, RDY_blockRead, EN_readMem, VALID_memVal;
  logic [5:0] writeMem_addr, readMem_addr;
  logic [33:0] writeMem_val, memVal_data;
  logic en8 = 1'b0;
  logic [63:0] a8 = '0, b8 = '0;
  logic rdy8, w8_en, rb8_rdy, re8, v8;
  logic [2:0] w8_addr, r8_addr;
  logic [18:0] w8_val, m8_data;
  logic [33:0] mem [64];
  logic [33:0] mdl [64];
  logic [33:0] exp_w[$], exp_r[$];
  int cyc = 0, pass_cnt = 0, fail_cnt = 0, total = 0;
  int wr_idx = 0, w8_idx = 0, first_w = -1, first_w8 = -1, acc_cyc = 0, acc8 = 0, last_v = 0, nval = 0;

  dnn_macbuff_param dut (
    .CLK(CLK), .RESET(RESET), .EN_mac(EN_mac), .RDY_mac(RDY_mac),
    .mac_vectA(mac_vectA), .mac_vectB(mac_vectB), .mac_signed(mac_signed),
    .EN_writeMem(EN_writeMem), .writeMem_addr(writeMem_addr), .writeMem_val(writeMem_val),
    .EN_blockRead(EN_blockRead), .blockRead_len(blockRead_len), .RDY_blockRead(RDY_blockRead),
    .EN_readMem(EN_readMem), .readMem_addr(readMem_addr), .readMem_val(readMem_val),
    .VALID_memVal(VALID_memVal), .memVal_data(memVal_data)
  );

  dnn_macbuff_param #(.LANES(8), .OPERAND_WIDTH(8), .ADDR_WIDTH(3)) dut8 (
    .CLK(CLK), .RESET(RESET), .EN_mac(en8), .RDY_mac(rdy8),
    .mac_vectA(a8), .mac_vectB(b8), .mac_signed(1'b0),
    .EN_writeMem(w8_en), .writeMem_addr(w8_addr), .writeMem_val(w8_val),
    .EN_blockRead(1'b0), .blockRead_len(4'd0), .RDY_blockRead(rb8_rdy),
    .EN_readMem(re8), .readMem_addr(r8_addr), .readMem_val(19'd0),
    .VALID_memVal(v8), .memVal_data(m8_data)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (EN_writeMem) mem[writeMem_addr] <= writeMem_val;
    if (EN_readMem) readMem_val <= mem[readMem_addr];
  end

  function automatic logic [63:0] mk(input int n);
    logic [63:0] v;
    for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'(i + 1 + n);
    return v;
  endfunction

  function automatic logic [33:0] dot(input logic [63:0] a, input logic [63:0] b, input bit s);
    longint acc, x, y;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      x = s ? longint'($signed(a[i*16 +: 16])) : longint'({48'd0, a[i*16 +: 16]});
      y = s ? longint'($signed(b[i*16 +: 16])) : longint'({48'd0, b[i*16 +: 16]});
      acc += x * y;
    end
    return acc[33:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (EN_writeMem) begin
      if (first_w < 0) first_w = cyc;
      chk("w_pending", 64'(exp_w.size() > 0), 64'd1);
      chk("w_addr", 64'(writeMem_addr), 64'(wr_idx));
      if (exp_w.size() > 0) chk("w_val", 64'(writeMem_val), 64'(exp_w.pop_front()));
      wr_idx++;
    end
    if (VALID_memVal) begin
      last_v = cyc;
      nval++;
      chk("r_pending", 64'(exp_r.size() > 0), 64'd1);
      if (exp_r.size() > 0) chk("r_val", 64'(memVal_data), 64'(exp_r.pop_front()));
    end
    if (w8_en) begin
      if (first_w8 < 0) first_w8 = cyc;
      chk("w8_addr", 64'(w8_addr), 64'(w8_idx));
      chk("w8_val", 64'(w8_val), 64'd520200);
      w8_idx++;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    EN_mac = 1'b0;
    EN_blockRead = 1'b0;
    exp_w.delete();
    exp_r.delete();
    step();
    RESET = 1'b0;
    wr_idx = 0;
    chk("rst_rdy_mac", 64'(RDY_mac), 64'd1);
    chk("rst_en_write", 64'(EN_writeMem), 64'd0);
    chk("rst_valid", 64'(VALID_memVal), 64'd0);
    chk("rst_rdy_rb", 64'(RDY_blockRead), 64'd0);
    chk("rst_en_read", 64'(EN_readMem), 64'd0);
  endtask

  // mode 0: A_i=B_i=i+1+n unsigned, no gaps; mode 1: signed extremes then random mixed-mode beats with gaps
  task automatic fill(input int mode, input int stop_at);
    int n;
    logic [63:0] a, b;
    bit s, gap;
    n = 0;
    wr_idx = 0;
    first_w = -1;
    for (int t = 0; t < 400 && n < 64 && n != stop_at; t++) begin
      gap = mode == 1 && $urandom_range(0, 2) == 0;
      if (mode == 0) begin
        a = mk(n);
        b = a;
        s = 1'b0;
      end else if (n < 2) begin
        a = 64'h8000_8000_8000_8000;
        b = n == 0 ? 64'h8000_8000_8000_8000 : 64'h7FFF_7FFF_7FFF_7FFF;
        s = 1'b1;
      end else begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        s = n % 2 == 1;
      end
      mac_vectA = a;
      mac_vectB = b;
      mac_signed = s;
      EN_mac = !gap;
      if (EN_mac && RDY_mac) begin
        mdl[n] = dot(a, b, s);
        exp_w.push_back(mdl[n]);
        if (n == 0) acc_cyc = cyc;
        n++;
      end
      step();
    end
    EN_mac = 1'b0;
  endtask

  task automatic wait_full();
    for (int t = 0; t < 300 && !RDY_blockRead; t++) step();
    chk("full", 64'(RDY_blockRead), 64'd1);
    chk("w_count", 64'(wr_idx), 64'd64);
    chk("w_left", 64'(exp_w.size()), 64'd0);
  endtask

  task automatic readback(input int len);
    int l;
    l = (len == 0 || len > 64) ? 64 : len;
    for (int i = 0; i < l; i++) exp_r.push_back(mdl[i]);
    nval = 0;
    blockRead_len = 7'(len);
    EN_blockRead = 1'b1;
    step();
    EN_blockRead = 1'b0;
    for (int t = 0; t < 300 && !RDY_mac; t++) step();
    chk("rd_done", 64'(RDY_mac), 64'd1);
    chk("rd_count", 64'(nval), 64'(l));
    chk("rd_left", 64'(exp_r.size()), 64'd0);
    chk("rdy_next", 64'(cyc), 64'(last_v + 1));
  endtask

  initial begin
    do_reset();
    chk("rst_wval", 64'(writeMem_val), 64'd0);
    chk("rst_mdata", 64'(memVal_data), 64'd0);
    a8 = '1;
    b8 = '1;
    en8 = 1'b1;
    acc8 = cyc;
    for (int t = 0; t < 40 && w8_idx < 8; t++) step();
    repeat (3) step();
    en8 = 1'b0;
    chk("lat8", 64'(first_w8 - acc8), 64'(mac_lat(8)));
    chk("w8_count", 64'(w8_idx), 64'd8);
    chk("rdy8_low", 64'(rdy8), 64'd0);
    chk("rb8_full", 64'(rb8_rdy), 64'd1);

    fill(0, -1);
    chk("rdy_fall", 64'(RDY_mac), 64'd0);
    EN_mac = 1'b1;
    repeat (3) begin
      step();
      chk("rdy_held_low", 64'(RDY_mac), 64'd0);
    end
    EN_mac = 1'b0;
    chk("lat", 64'(first_w - acc_cyc), 64'(mac_lat(4)));
    wait_full();
    chk("entry0", 64'(mem[0]), 64'd30);
    readback(0);

    blockRead_len = '0;
    EN_blockRead = 1'b1;
    step();
    EN_blockRead = 1'b0;
    step();
    chk("illegal_rb_rdy", 64'(RDY_blockRead), 64'd0);
    chk("illegal_rb_read", 64'(EN_readMem), 64'd0);
    chk("illegal_rb_mac", 64'(RDY_mac), 64'd1);

    fill(1, -1);
    wait_full();
    chk("signed_min_sq", 64'(mem[0]), 64'h1_0000_0000);
    chk("signed_min_max", 64'(mem[1]), 64'h3_0002_0000);
    readback(5);

    fill(0, 30);
    do_reset();
    repeat (10) step();
    fill(0, -1);
    wait_full();
    for (int i = 0; i < 64; i++) exp_r.push_back(mdl[i]);
    nval = 0;
    blockRead_len = '0;
    EN_blockRead = 1'b1;
    step();
    EN_blockRead = 1'b0;
    for (int t = 0; t < 100 && nval < 10; t++) step();
    chk("mid_read", 64'(nval), 64'd10);
    do_reset();
    repeat (10) step();

    fill(0, -1);
    wait_full();
    readback(0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
